// File: rtl/disp_source_ctrl.sv
// rtl/disp_source_ctrl.sv - registered display-source selector with RAM memory view
// Optional channel auto-scan is built only when DISP_AUTO_SCAN_EN is defined.
module disp_source_ctrl #(
    parameter int               DATA_W     = 32,
    parameter int               CNT_W      = 16,
    parameter int               NCH        = 6,
    parameter int               SEL_W      = 3,
    parameter int               MEM_SEL    = 6,
    parameter logic [NCH-1:0]   CH_LEFT    = 6'b111100,
    parameter int               ADDR_W     = 12,
    parameter int               RAM_LAT    = 1,
    parameter int               SCAN_TICKS = 50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SEL_W-1:0]      sel,
    input  logic [NCH*DATA_W-1:0] ch_data,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic                  refresh,
    input  logic                  hold,
    input  logic                  scan_en,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  mem_req,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_busy,
    output logic                  mem_valid,
    output logic [SEL_W-1:0]      disp_sel_cur,
    output logic [DATA_W-1:0]     disp_out
);

    typedef enum logic [1:0] {M_IDLE, M_REQ, M_WAIT, M_DONE} mstate_t;

    localparam logic [SEL_W-1:0] MEM_CODE = SEL_W'(MEM_SEL);
    localparam logic [SEL_W-1:0] NCH_CODE = SEL_W'(NCH);
    localparam logic [2:0]       LAT_LAST = 3'(RAM_LAT);

    logic             scan_active;
    logic [SEL_W-1:0] scan_sel;
    logic [SEL_W-1:0] eff_sel;
    logic [SEL_W-1:0] ch_idx;
    logic             mem_mode;
    logic [DATA_W-1:0] ch_word;
    logic [DATA_W-1:0] ch_raw;

`ifdef DISP_AUTO_SCAN_EN
    localparam int               SCNT_W    = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SCAN_TICKS - 1);
    localparam logic [SEL_W-1:0]  IDX_LAST  = SEL_W'(NCH - 1);

    logic [SCNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [SEL_W-1:0]  scan_idx_q, scan_idx_d;

    // Dropping scan_en clears the walk so the next enable restarts at channel 0.
    always_comb begin
        scan_cnt_d = '0;
        scan_idx_d = '0;
        if (scan_en) begin
            if (scan_cnt_q == SCNT_LAST) begin
                scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
            end else begin
                scan_cnt_d = scan_cnt_q + 1'b1;
                scan_idx_d = scan_idx_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
        end
    end

    assign scan_active = scan_en;
    assign scan_sel    = scan_idx_q;
`else
    logic unused_scan;
    assign unused_scan = scan_en ^ (SCAN_TICKS == 0);
    assign scan_active = 1'b0;
    assign scan_sel    = '0;
`endif

    assign eff_sel  = scan_active ? scan_sel : sel;
    assign mem_mode = (eff_sel == MEM_CODE);
    assign ch_idx   = (eff_sel < NCH_CODE) ? eff_sel : '0;

    always_comb begin
        ch_raw = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_idx == SEL_W'(i)) begin
                ch_raw = ch_data[i*DATA_W +: DATA_W];
            end
        end
        ch_word = ch_raw;
        for (int i = 0; i < NCH; i++) begin
            if (ch_idx == SEL_W'(i) && CH_LEFT[i]) begin
                ch_word = ch_raw << (DATA_W - CNT_W);
            end
        end
    end

    mstate_t           state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_busy_q, mem_busy_d;
    logic              mem_valid_q, mem_valid_d;
    logic [2:0]        lat_q, lat_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] mdata_q, mdata_d;
    logic [DATA_W-1:0] disp_q, disp_d;
    logic [SEL_W-1:0]  sel_cur_q, sel_cur_d;
    logic              rd_done;

    // A refresh seen mid-read is remembered so it still triggers one re-read after M_DONE.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_busy_d  = mem_busy_q;
        mem_valid_d = mem_valid_q;
        lat_d       = lat_q;
        pend_d      = pend_q;
        mdata_d     = mdata_q;
        rd_done     = 1'b0;
        if (!mem_mode) begin
            state_d     = M_IDLE;
            mem_busy_d  = 1'b0;
            mem_valid_d = 1'b0;
            pend_d      = 1'b0;
            lat_d       = '0;
        end else begin
            case (state_q)
                M_IDLE: begin
                    state_d     = M_REQ;
                    mem_addr_d  = in_addr;
                    mem_busy_d  = 1'b1;
                    mem_valid_d = 1'b0;
                end
                M_REQ: begin
                    state_d = M_WAIT;
                    lat_d   = 3'd1;
                    pend_d  = pend_q | refresh;
                end
                M_WAIT: begin
                    pend_d = pend_q | refresh;
                    if (lat_q == LAT_LAST) begin
                        state_d     = M_DONE;
                        mdata_d     = mem_rdata;
                        mem_busy_d  = 1'b0;
                        mem_valid_d = 1'b1;
                        rd_done     = 1'b1;
                    end else begin
                        lat_d = lat_q + 3'd1;
                    end
                end
                M_DONE: begin
                    if (pend_q || refresh || (in_addr != mem_addr_q)) begin
                        state_d     = M_REQ;
                        mem_addr_d  = in_addr;
                        mem_busy_d  = 1'b1;
                        mem_valid_d = 1'b0;
                        pend_d      = 1'b0;
                    end
                end
                default: state_d = M_IDLE;
            endcase
        end
    end

    // Under hold the display is frozen; mdata_q lets it catch up once hold drops.
    always_comb begin
        disp_d    = disp_q;
        sel_cur_d = sel_cur_q;
        if (!hold) begin
            if (mem_mode) begin
                sel_cur_d = MEM_CODE;
                if (rd_done) begin
                    disp_d = mem_rdata;
                end else if (state_q == M_DONE) begin
                    disp_d = mdata_q;
                end
            end else begin
                sel_cur_d = ch_idx;
                disp_d    = ch_word;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= M_IDLE;
            mem_addr_q  <= '0;
            mem_busy_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            lat_q       <= '0;
            pend_q      <= 1'b0;
            mdata_q     <= '0;
            disp_q      <= '0;
            sel_cur_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_busy_q  <= mem_busy_d;
            mem_valid_q <= mem_valid_d;
            lat_q       <= lat_d;
            pend_q      <= pend_d;
            mdata_q     <= mdata_d;
            disp_q      <= disp_d;
            sel_cur_q   <= sel_cur_d;
        end
    end

    assign mem_req      = (state_q == M_REQ) && mem_mode;
    assign mem_addr     = mem_addr_q;
    assign mem_busy     = mem_busy_q;
    assign mem_valid    = mem_valid_q;
    assign disp_sel_cur = sel_cur_q;
    assign disp_out     = disp_q;

endmodule

// File: doc/disp_source_ctrl.md
Name: disp_source_ctrl

Overview:
- Registered successor to the board's display-source selector for the single-cycle CPU FPGA build.
- Picks one of NCH 32-bit status channels for the 7-segment display: syscall output, PC, and the cycle, jump and branch counters.
- Left-aligns counter-type channels.
- Adds the memory-view mode: a real RAM read FSM with a fixed-latency handshake, plus an optional auto-scan through the channels.
- Sits between the CPU datapath/counters and the seven-segment driver.

Parameters:
- DATA_W, 32, display word width.
- CNT_W, 16, width of counter-type channels.
- NCH, 6, number of status channels; channel 0 is the default (syscall) channel.
- SEL_W, 3, width of the select switches.
- MEM_SEL, 6, select code for memory-view mode; must be >= NCH.
- CH_LEFT, 6'b111100, per-channel mask. Bit i=1 means channel i is a counter: low CNT_W bits are shown in bits [DATA_W-1:DATA_W-CNT_W] and the lower bits are zero.
- ADDR_W, 12, RAM word address width.
- RAM_LAT, 1, cycles from a mem_req cycle to valid mem_rdata; legal range 1..7.
- SCAN_TICKS, 50000000, clocks per channel in auto-scan.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- sel  in  SEL_W  display source switches.
- ch_data  in  NCH*DATA_W  flattened channels; channel i occupies [i*DATA_W +: DATA_W].
- in_addr  in  ADDR_W  memory-view address switches.
- refresh  in  1  one-cycle pulse; forces a memory re-read.
- hold  in  1  freezes the display.
- scan_en  in  1  auto-scan request (only active with the optional feature).
- mem_rdata  in  DATA_W  RAM read data.
- mem_req  out  1  one-cycle RAM read strobe.
- mem_addr  out  ADDR_W  RAM address, stable from the mem_req cycle until the read completes.
- mem_busy  out  1  read in flight.
- mem_valid  out  1  disp_out holds data read from mem_addr.
- disp_sel_cur  out  SEL_W  source currently shown.
- disp_out  out  DATA_W  display word.

Behaviour:
- Reset: asynchronous, active-high.
  - disp_out=0, disp_sel_cur=0, mem_req=0, mem_addr=0, mem_busy=0, mem_valid=0.
  - FSM returns to M_IDLE; scan index and scan counter clear.
  - Takes effect immediately, including in the middle of a read; no request is reissued after release until the mode conditions hold again.
- Effective select eff_sel:
  - Equals the scan index when auto-scan is active, else sel.
  - Codes 0..NCH-1 select a channel; MEM_SEL selects memory view; any other code maps to channel 0.
- Channel mode:
  - disp_out and disp_sel_cur update on the next clock edge, a 1-cycle latency.
  - CH_LEFT formatting is applied in the same cycle.
- Memory FSM states: M_IDLE, M_REQ, M_WAIT, M_DONE.
  - M_IDLE -> M_REQ when eff_sel==MEM_SEL.
  - M_REQ: mem_req=1 for exactly one cycle; mem_addr<=in_addr; mem_busy=1; mem_valid=0. Always goes to M_WAIT.
  - M_WAIT: counts RAM_LAT cycles. mem_rdata is sampled on the edge RAM_LAT cycles after the mem_req cycle, disp_out takes it, mem_busy=0, mem_valid=1, and the FSM goes to M_DONE.
  - M_DONE -> M_REQ when in_addr != mem_addr or refresh=1.
  - M_DONE stays in M_DONE otherwise.
  - During M_REQ/M_WAIT, disp_out keeps its previous value.
- Address change or refresh during M_REQ/M_WAIT: the current read completes and its data is shown for one cycle, then a new request is issued.
- Leaving memory mode (eff_sel != MEM_SEL) in any state:
  - FSM goes to M_IDLE on the next edge; mem_busy=0 and mem_valid=0.
  - Any in-flight data is discarded.
  - The channel display takes effect on that same edge.
- hold=1:
  - disp_out and disp_sel_cur are frozen.
  - The FSM and scan keep running.
  - A read completing under hold updates mem_valid but not disp_out. disp_out is refreshed on the first cycle after hold drops.
- mem_req is never asserted while eff_sel != MEM_SEL.

Optional Feature:
- Macro: DISP_AUTO_SCAN_EN.
- With the macro defined:
  - scan_en=1 makes auto-scan active. The scan index steps 0,1,...,NCH-1 and wraps to 0, holding each channel for SCAN_TICKS clocks.
  - Memory view is skipped.
  - When scan_en drops, the index and counter clear on the next edge and sel governs again.
- Without the macro: no scan counter logic is built, scan_en is ignored, and eff_sel=sel.

Test Plan:
- Assert reset mid-cycle during M_WAIT -> all outputs 0 with no clock edge; after release with sel=0 and ch0=0x0000000A -> disp_out=0x0000000A one edge later.
- sel=1, ch1=0x00400020 -> disp_out=0x00400020 and disp_sel_cur=1 on the next edge; sel=7 -> ch0 shown.
- sel=2, ch2=0xFFFF1234, CH_LEFT bit2=1 -> disp_out=0x12340000.
- sel=6, in_addr=0x010, RAM_LAT=2, mem_rdata=0xDEADBEEF -> one mem_req pulse with mem_addr=0x010; disp_out=0xDEADBEEF and mem_valid=1 two edges after the request. Then change in_addr to 0x011 -> exactly one new mem_req; a refresh pulse -> one more.
- Memory read in flight, switch sel to 1 -> no further mem_req, mem_busy=0 and mem_valid=0 next edge, ch1 shown; hold=1 with ch1 changing -> disp_out is unchanged until hold drops.
- With DISP_AUTO_SCAN_EN and SCAN_TICKS=4, NCH=6, scan_en=1 -> disp_sel_cur runs 0,1,2,3,4,5,0 with 4 clocks each and mem_req never asserts; without the macro, scan_en=1 has no effect.
